// File: rtl/interpolator.sv
// Sample-rate increaser: emits L = 2**LOG2L samples per ce_in period on ce_fast ticks.
// Define LINEAR_INTERP_EN for linear ramps; otherwise each tick repeats the latest sample (zero-order hold).
module interpolator #(
    parameter int LOG2L = 3,
    parameter int DW    = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_ce_in,
    input  logic [DW-1:0] i_sig_in,
    input  logic          i_ce_fast,
    output logic          o_ce_out,
    output logic [DW-1:0] o_sig_out,
    output logic          o_overrun,
    output logic          o_underrun
);

    localparam int            PW   = LOG2L + 1;
    localparam logic [PW-1:0] PH_L = PW'(2 ** LOG2L);

    logic [DW-1:0] r_xCur;
    logic [PW-1:0] r_ph;
    logic          r_ceOut;
    logic [DW-1:0] r_sigOut;
    logic          r_overrun;
    logic          r_underrun;

    logic          w_midRamp;
    logic          w_phActive;

    // ph == 0 means a fresh period not yet started, ph == L means idle/holding
    assign w_midRamp  = (r_ph != '0) && (r_ph != PH_L);
    assign w_phActive = (r_ph < PH_L);

`ifdef LINEAR_INTERP_EN
    localparam int AW = DW + LOG2L + 1;

    logic [DW:0]   r_delta;
    logic [AW-1:0] r_acc;
    logic [DW:0]   w_delta;
    logic [AW-1:0] w_deltaExt;
    logic [AW-1:0] w_rDeltaExt;
    logic [AW-1:0] w_accLoad;

    // acc holds the ramp value scaled by L, so the output is a plain bit-select (floor)
    assign w_delta     = {i_sig_in[DW-1], i_sig_in} - {r_xCur[DW-1], r_xCur};
    assign w_deltaExt  = {{(AW-DW-1){w_delta[DW]}}, w_delta};
    assign w_rDeltaExt = {{(AW-DW-1){r_delta[DW]}}, r_delta};
    assign w_accLoad   = {{(AW-DW){r_xCur[DW-1]}}, r_xCur} << LOG2L;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_xCur     <= '0;
            r_ph       <= PH_L;
            r_ceOut    <= 1'b0;
            r_sigOut   <= '0;
            r_overrun  <= 1'b0;
            r_underrun <= 1'b0;
`ifdef LINEAR_INTERP_EN
            r_delta    <= '0;
            r_acc      <= '0;
`endif
        end else begin
            r_ceOut    <= i_ce_fast;
            r_overrun  <= 1'b0;
            r_underrun <= 1'b0;
            if (i_ce_in) begin
                r_xCur    <= i_sig_in;
                r_overrun <= w_midRamp;
`ifdef LINEAR_INTERP_EN
                r_delta   <= w_delta;
`endif
                if (i_ce_fast) begin
                    // same-cycle tick consumes k=0 of the new period
`ifdef LINEAR_INTERP_EN
                    r_sigOut <= r_xCur;
                    r_acc    <= w_accLoad + w_deltaExt;
`else
                    r_sigOut <= i_sig_in;
`endif
                    r_ph     <= PW'(1);
                end else begin
`ifdef LINEAR_INTERP_EN
                    r_acc    <= w_accLoad;
`endif
                    r_ph     <= '0;
                end
            end else if (i_ce_fast) begin
                if (w_phActive) begin
`ifdef LINEAR_INTERP_EN
                    r_sigOut <= r_acc[LOG2L +: DW];
                    r_acc    <= r_acc + w_rDeltaExt;
`else
                    r_sigOut <= r_xCur;
`endif
                    r_ph     <= r_ph + 1'b1;
                end else begin
                    r_sigOut   <= r_xCur;
                    r_underrun <= 1'b1;
                end
            end
        end
    end

    assign o_ce_out   = r_ceOut;
    assign o_sig_out  = r_sigOut;
    assign o_overrun  = r_overrun;
    assign o_underrun = r_underrun;

endmodule

// File: tb/tb_interpolator.sv
// Directed bench for interpolator (LOG2L=3, DW=16); expectations follow LINEAR_INTERP_EN.
module tb_interpolator;

    localparam int LOG2L = 3;
    localparam int DW    = 16;
`ifdef LINEAR_INTERP_EN
    localparam bit LIN = 1'b1;
`else
    localparam bit LIN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ceIn = 1'b0;
    logic [DW-1:0] sigIn = '0;
    logic          ceFast = 1'b0;
    logic          ceOut;
    logic [DW-1:0] sigOut;
    logic          overrun;
    logic          underrun;

    int checks   = 0;
    int failures = 0;

    interpolator #(.LOG2L(LOG2L), .DW(DW)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_ce_in    (ceIn),
        .i_sig_in   (sigIn),
        .i_ce_fast  (ceFast),
        .o_ce_out   (ceOut),
        .o_sig_out  (sigOut),
        .o_overrun  (overrun),
        .o_underrun (underrun)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic signed [31:0] actual,
                               input logic signed [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the capturing edge
    task automatic applyStimulus(input logic ci, input int value, input logic cf);
        @(negedge clk);
        ceIn   = ci;
        sigIn  = DW'(value);
        ceFast = cf;
        @(posedge clk);
        #1;
        ceIn   = 1'b0;
        ceFast = 1'b0;
    endtask

    task automatic tick(input string tag, input int expSig, input logic expUnder);
        applyStimulus(1'b0, 0, 1'b1);
        checkOutput({tag, "_ce_out"}, {31'd0, ceOut}, 1);
        checkOutput({tag, "_sig"}, $signed(sigOut), expSig);
        checkOutput({tag, "_underrun"}, {31'd0, underrun}, {31'd0, expUnder});
        checkOutput({tag, "_overrun"}, {31'd0, overrun}, 0);
    endtask

    task automatic load(input string tag, input int value, input logic expOver);
        applyStimulus(1'b1, value, 1'b0);
        checkOutput({tag, "_ce_out_idle"}, {31'd0, ceOut}, 0);
        checkOutput({tag, "_overrun"}, {31'd0, overrun}, {31'd0, expOver});
        checkOutput({tag, "_underrun"}, {31'd0, underrun}, 0);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        ceIn = 1'b1;
        sigIn = DW'(1234);
        ceFast = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        ceIn = 1'b0;
        ceFast = 1'b0;
        checkOutput("rst_ce_out", {31'd0, ceOut}, 0);
        checkOutput("rst_sig", $signed(sigOut), 0);
        checkOutput("rst_overrun", {31'd0, overrun}, 0);
        checkOutput("rst_underrun", {31'd0, underrun}, 0);
    endtask

    initial begin
        $display("[TB] interpolator bench, linear=%0d", LIN);

        // 1: idle after reset holds zero and flags underrun
        doReset();
        tick("t1a", 0, 1'b1);
        tick("t1b", 0, 1'b1);

        // 2: ramp 0 -> 800
        load("t2_load0", 0, 1'b0);
        for (int k = 0; k < 8; k++) tick("t2_zero", 0, 1'b0);
        load("t2_load800", 800, 1'b0);
        for (int k = 0; k < 8; k++) tick("t2_ramp", LIN ? 100 * k : 800, 1'b0);

        // 3: negative ramp 800 -> -8
        load("t3_load", -8, 1'b0);
        for (int k = 0; k < 8; k++) tick("t3_ramp", LIN ? 800 - 101 * k : -8, 1'b0);

        // 4: return to 0, then floor rounding on a small step
        load("t4_load0", 0, 1'b0);
        for (int k = 0; k < 8; k++) tick("t4_back", LIN ? -8 + k : 0, 1'b0);
        load("t4_load3", 3, 1'b0);
        for (int k = 0; k < 8; k++) tick("t4_floor", LIN ? (3 * k) / 8 : 3, 1'b0);

        // 5: overrun mid-ramp (reset also exercises mid-state recovery)
        load("t5_pre", 500, 1'b0);
        tick("t5_pre_tick", LIN ? 3 : 500, 1'b0);
        doReset();
        load("t5_load800", 800, 1'b0);
        for (int k = 0; k < 3; k++) tick("t5_ramp", LIN ? 100 * k : 800, 1'b0);
        load("t5_over", 0, 1'b1);
        tick("t5_after", LIN ? 800 : 0, 1'b0);

        // 6: load and tick in the same cycle
        doReset();
        applyStimulus(1'b1, 800, 1'b1);
        checkOutput("t6_ce_out", {31'd0, ceOut}, 1);
        checkOutput("t6_sig", $signed(sigOut), LIN ? 0 : 800);
        checkOutput("t6_overrun", {31'd0, overrun}, 0);
        checkOutput("t6_underrun", {31'd0, underrun}, 0);
        for (int k = 1; k < 8; k++) tick("t6_ramp", LIN ? 100 * k : 800, 1'b0);
        tick("t6_end", 800, 1'b1);

        // idle cycle after a tick must drop ce_out
        applyStimulus(1'b0, 0, 1'b0);
        checkOutput("idle_ce_out", {31'd0, ceOut}, 0);
        checkOutput("idle_sig_hold", $signed(sigOut), 800);
        checkOutput("idle_underrun", {31'd0, underrun}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
